// File: rtl/sample_ring_buffer_if.sv
// ============================================================================
// Module   : sample_ring_buffer_if
// Purpose  : Sample strobe, read port and status bundle for sample_ring_buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sample_ring_buffer_if #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 256,
    parameter int CHANNELS = 2
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      in_flag;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      clear;
    logic                      rd_en;
    logic [CW-1:0]             rd_ch;
    logic [AW-1:0]             rd_offset;
    logic [WIDTH-1:0]          rd_data;
    logic                      rd_valid;
    logic                      new_sample;
    logic [AW:0]               fill;
    logic [CHANNELS-1:0]       flag_zero;
    logic                      all_zero;
    logic                      busy;
    logic                      drop_err;

    modport master (
        output in_flag, in_data, clear, rd_en, rd_ch, rd_offset,
        input  rd_data, rd_valid, new_sample, fill, flag_zero, all_zero, busy, drop_err
    );

    modport slave (
        input  in_flag, in_data, clear, rd_en, rd_ch, rd_offset,
        output rd_data, rd_valid, new_sample, fill, flag_zero, all_zero, busy, drop_err
    );
endinterface

`default_nettype wire

// File: rtl/sample_ring_buffer.sv
// ============================================================================
// Module   : sample_ring_buffer
// Purpose  : Per-channel circular sample history with x[n-k] reads, zero-run
//            tracking for sleep control and a one-address-per-cycle flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sample_ring_buffer #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 256,
    parameter int CHANNELS = 2,
    parameter int ZERO_RUN = 800
) (
    input  wire logic          Sclk,
    input  wire logic          Reset_n,
    sample_ring_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int ZW = $clog2(ZERO_RUN + 1);

    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
    localparam logic [AW:0]   c_fill_max  = (AW + 1)'(DEPTH);
    localparam logic [ZW-1:0] c_zrun      = ZW'(ZERO_RUN);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              state_q;
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       clr_addr_q;
    logic [AW:0]         fill_q;
    logic                in_flag_q;
    logic                new_sample_q;
    logic                busy_q;
    logic                drop_err_q;
    logic                rd_valid_q;
    logic [WIDTH-1:0]    rd_data_q;
    logic [WIDTH-1:0]    mem_q [CHANNELS][DEPTH];

    logic                w_rise;
    logic                w_last;
    logic                w_accept;
    logic [AW-1:0]       w_rd_addr;
    logic [WIDTH-1:0]    w_rd_value;
    logic [CHANNELS-1:0] w_flag_zero;

    assign w_rise   = bus.in_flag & ~in_flag_q;
    assign w_last   = (state_q == S_CLEAR) && (clr_addr_q == c_last_addr);
    // The final flush cycle already accepts, so a sample can land on the edge busy drops.
    assign w_accept = w_rise && ((state_q == S_IDLE) || w_last);
    assign w_rd_addr = wr_ptr_q - AW'(1) - bus.rd_offset;

    always_comb begin
        w_rd_value = '0;
        if ((state_q == S_IDLE) && (32'(bus.rd_ch) < CHANNELS) &&
            ({1'b0, bus.rd_offset} < fill_q)) begin
            w_rd_value = mem_q[bus.rd_ch][w_rd_addr];
        end
    end

    // Two write ports: during the last flush cycle the wipe and a new sample hit different addresses.
    always_ff @(posedge Sclk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_accept) begin
                mem_q[c][wr_ptr_q] <= bus.in_data[c*WIDTH +: WIDTH];
            end
            if (state_q == S_CLEAR) begin
                mem_q[c][clr_addr_q] <= '0;
            end
        end
    end

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            clr_addr_q   <= '0;
            fill_q       <= '0;
            in_flag_q    <= 1'b0;
            new_sample_q <= 1'b0;
            busy_q       <= 1'b0;
            drop_err_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            in_flag_q    <= bus.in_flag;
            new_sample_q <= w_accept;
            rd_valid_q   <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= w_rd_value;
            end
            if (w_accept) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (fill_q != c_fill_max) begin
                    fill_q <= fill_q + (AW + 1)'(1);
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.clear) begin
                        state_q    <= S_CLEAR;
                        busy_q     <= 1'b1;
                        clr_addr_q <= '0;
                        wr_ptr_q   <= '0;
                        fill_q     <= '0;
                        drop_err_q <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    clr_addr_q <= clr_addr_q + AW'(1);
                    if (w_rise && !w_last) begin
                        drop_err_q <= 1'b1;
                    end
                    if (w_last) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [ZW-1:0]    zcnt_q;
        logic             zflag_q;
        logic [WIDTH-1:0] w_sample;

        assign w_sample = bus.in_data[c*WIDTH +: WIDTH];

        always_ff @(posedge Sclk or negedge Reset_n) begin
            if (!Reset_n) begin
                zcnt_q  <= '0;
                zflag_q <= 1'b0;
            end else if (w_accept) begin
                if (w_sample == '0) begin
                    if (zcnt_q != c_zrun) begin
                        zcnt_q <= zcnt_q + ZW'(1);
                    end
                    zflag_q <= (zcnt_q >= (c_zrun - ZW'(1)));
                end else begin
                    zcnt_q  <= '0;
                    zflag_q <= 1'b0;
                end
            end
        end

        assign w_flag_zero[c] = zflag_q;
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.new_sample = new_sample_q;
    assign bus.fill       = fill_q;
    assign bus.flag_zero  = w_flag_zero;
    assign bus.all_zero   = &w_flag_zero;
    assign bus.busy       = busy_q;
    assign bus.drop_err   = drop_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_ring_buffer.sv
// ============================================================================
// Module   : tb_sample_ring_buffer
// Purpose  : Directed self-checking bench for sample_ring_buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sample_ring_buffer;
    localparam int WIDTH    = 16;
    localparam int DEPTH    = 256;
    localparam int CHANNELS = 2;
    localparam int ZERO_RUN = 800;

    logic Sclk;
    logic Reset_n;
    int   n_checks;
    int   n_errors;
    int   cnt;
    logic [WIDTH-1:0] rd_val;

    sample_ring_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) bus ();

    sample_ring_buffer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .ZERO_RUN(ZERO_RUN)
    ) u_dut (
        .Sclk   (Sclk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    initial Sclk = 1'b0;
    always #5 Sclk = ~Sclk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Sclk);
        #1;
    endtask

    task automatic write_sample(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        bus.in_data = {d1, d0};
        bus.in_flag = 1'b1;
        tick();
        bus.in_flag = 1'b0;
        tick();
    endtask

    task automatic write_n(input int n, input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        for (int i = 0; i < n; i++) write_sample(d0, d1);
    endtask

    task automatic read(input logic ch, input int off, output logic [WIDTH-1:0] val);
        bus.rd_en     = 1'b1;
        bus.rd_ch     = ch;
        bus.rd_offset = off[7:0];
        tick();
        bus.rd_en = 1'b0;
        check("rd_valid after rd_en", 32'(bus.rd_valid), 32'd1);
        val = bus.rd_data;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        Reset_n       = 1'b0;
        bus.in_flag   = 1'b0;
        bus.in_data   = '0;
        bus.clear     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_ch     = '0;
        bus.rd_offset = '0;
        repeat (3) tick();
        check("reset rd_data",    32'(bus.rd_data),    32'd0);
        check("reset rd_valid",   32'(bus.rd_valid),   32'd0);
        check("reset new_sample", 32'(bus.new_sample), 32'd0);
        check("reset fill",       32'(bus.fill),       32'd0);
        check("reset flag_zero",  32'(bus.flag_zero),  32'd0);
        check("reset all_zero",   32'(bus.all_zero),   32'd0);
        check("reset busy",       32'(bus.busy),       32'd0);
        check("reset drop_err",   32'(bus.drop_err),   32'd0);
        Reset_n = 1'b1;
        tick();

        // Three samples, then history reads including zero padding.
        bus.in_data = {16'h0101, 16'd1};
        bus.in_flag = 1'b1;
        tick();
        check("new_sample pulse", 32'(bus.new_sample), 32'd1);
        bus.in_flag = 1'b0;
        tick();
        check("new_sample drop", 32'(bus.new_sample), 32'd0);
        write_sample(16'd2, 16'h0102);
        write_sample(16'd3, 16'h0103);
        check("fill 3", 32'(bus.fill), 32'd3);
        read(1'b0, 0, rd_val); check("ch0 off0", 32'(rd_val), 32'd3);
        read(1'b0, 1, rd_val); check("ch0 off1", 32'(rd_val), 32'd2);
        read(1'b0, 2, rd_val); check("ch0 off2", 32'(rd_val), 32'd1);
        read(1'b0, 3, rd_val); check("ch0 off3 pad", 32'(rd_val), 32'd0);
        read(1'b1, 0, rd_val); check("ch1 off0", 32'(rd_val), 32'h0103);
        tick();
        check("rd_valid idle", 32'(bus.rd_valid), 32'd0);

        // Read and accept on the same edge sees the previous newest sample.
        bus.in_data   = {16'h0104, 16'd4};
        bus.in_flag   = 1'b1;
        bus.rd_en     = 1'b1;
        bus.rd_ch     = 1'b0;
        bus.rd_offset = 8'd0;
        tick();
        bus.rd_en = 1'b0;
        check("read+accept old newest", 32'(bus.rd_data), 32'd3);
        check("read+accept fill", 32'(bus.fill), 32'd4);

        // in_flag already high: stretch to 4 cycles total, expect one pulse.
        bus.in_flag = 1'b0;
        tick();
        cnt = 0;
        bus.in_flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.new_sample) cnt++;
        end
        bus.in_flag = 1'b0;
        tick();
        if (bus.new_sample) cnt++;
        check("held strobe pulses", 32'(cnt), 32'd1);
        check("held strobe fill", 32'(bus.fill), 32'd5);

        // Wrap: DEPTH+5 samples with ch0 = index.
        for (int i = 0; i < DEPTH + 5; i++) write_sample(WIDTH'(i), 16'h0055);
        check("wrap fill sat", 32'(bus.fill), 32'(DEPTH));
        read(1'b0, 0, rd_val);         check("wrap off0", 32'(rd_val), 32'(DEPTH + 4));
        read(1'b0, DEPTH - 1, rd_val); check("wrap offmax", 32'(rd_val), 32'd5);

        // Zero-run tracking.
        write_n(ZERO_RUN - 1, 16'd0, 16'd7);
        check("zero 799", 32'(bus.flag_zero), 32'b00);
        write_sample(16'd0, 16'd0);
        check("zero 800", 32'(bus.flag_zero), 32'b01);
        check("all_zero one ch", 32'(bus.all_zero), 32'd0);
        write_n(ZERO_RUN - 2, 16'd0, 16'd0);
        check("ch1 zero 799", 32'(bus.flag_zero), 32'b01);
        write_sample(16'd0, 16'd0);
        check("both flagged", 32'(bus.flag_zero), 32'b11);
        check("all_zero both", 32'(bus.all_zero), 32'd1);
        write_sample(16'd9, 16'd0);
        check("nonzero clears ch0", 32'(bus.flag_zero), 32'b10);
        check("all_zero cleared", 32'(bus.all_zero), 32'd0);

        // Flush with a dropped sample and a read during the wipe.
        write_n(10, 16'h00AB, 16'h00CD);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        cnt = 0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            if (bus.busy) cnt++;
            bus.in_flag = (i == 5);
            bus.rd_en   = (i == 6);
            tick();
            if (i == 6) begin
                check("flush read data",  32'(bus.rd_data),  32'd0);
                check("flush read valid", 32'(bus.rd_valid), 32'd1);
            end
        end
        bus.in_flag = 1'b0;
        bus.rd_en   = 1'b0;
        check("flush busy cycles", 32'(cnt), 32'(DEPTH));
        check("flush drop_err", 32'(bus.drop_err), 32'd1);
        check("flush fill", 32'(bus.fill), 32'd0);
        check("flush busy low", 32'(bus.busy), 32'd0);
        read(1'b0, 0, rd_val);  check("flush off0",  32'(rd_val), 32'd0);
        read(1'b1, 9, rd_val);  check("flush ch1 off9", 32'(rd_val), 32'd0);
        write_sample(16'hAAAA, 16'hBBBB);
        read(1'b0, 0, rd_val);  check("post flush off0", 32'(rd_val), 32'hAAAA);
        read(1'b0, 1, rd_val);  check("post flush off1", 32'(rd_val), 32'd0);
        check("drop_err sticky", 32'(bus.drop_err), 32'd1);

        // Asynchronous reset in the middle of a flush.
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        write_sample(16'h7777, 16'h7777);
        check("midflush drop", 32'(bus.drop_err), 32'd1);
        Reset_n = 1'b0;
        #2;
        check("async busy",     32'(bus.busy),     32'd0);
        check("async fill",     32'(bus.fill),     32'd0);
        check("async drop_err", 32'(bus.drop_err), 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        write_sample(16'h1234, 16'h0001);
        read(1'b0, 0, rd_val);  check("post reset off0", 32'(rd_val), 32'h1234);
        check("post reset fill", 32'(bus.fill), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
